// File: rtl/q_issue_pkg.sv
// Shared types for the timed quantum-issue path: FIFO entry layout, run states
// and instruction-kind encodings.
package q_issue_pkg;

  localparam int Q_TS_W = 32;

  localparam logic KIND_SLM = 1'b0;
  localparam logic KIND_ROT = 1'b1;

  typedef struct packed {
    logic [Q_TS_W-1:0] ts;
    logic              kind;
    logic [31:0]       inst;
  } q_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } q_state_e;

  // Unsigned "timer has reached the timestamp" test used for release decisions.
  function automatic logic ts_reached(input logic [Q_TS_W-1:0] timer,
                                      input logic [Q_TS_W-1:0] ts);
    return timer >= ts;
  endfunction

endpackage

// File: rtl/q_timed_issue_if.sv
// Issue channel from the timed FIFO to the pulse/AWG backend (valid/ready).
interface q_timed_issue_if;
  logic        o_issue_valid;
  logic        i_issue_ready;
  logic [31:0] o_issue_inst;
  logic        o_issue_kind;

  modport master (
    output o_issue_valid,
    output o_issue_inst,
    output o_issue_kind,
    input  i_issue_ready
  );

  modport slave (
    input  o_issue_valid,
    input  o_issue_inst,
    input  o_issue_kind,
    output i_issue_ready
  );
endinterface

// File: rtl/q_ts_fifo.sv
// Synchronous first-word-fall-through FIFO of timestamped quantum ops.
// A push while full is only taken when a pop frees the slot in the same cycle.
module q_ts_fifo
  import q_issue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  q_entry_t push_data,
  input  logic     pop,
  output q_entry_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  q_entry_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/q_timed_issue.sv
// Quantum-side receiver: timestamps incoming quantum ops, releases them to the
// backend when the run timer reaches their timestamp, and keeps a result file.
module q_timed_issue
  import q_issue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TS_W   = Q_TS_W,
  parameter int MEAS_N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_end,
  input  logic             q_time_write,
  input  logic             q_time_sel,
  input  logic [TS_W-1:0]  q_time_reg,
  input  logic             q_slm,
  input  logic             q_rot,
  input  logic [31:0]      q_inst,
  output logic             o_cc_full,
  q_timed_issue_if.master  iss,
  input  logic             i_meas_valid,
  input  logic [4:0]       i_meas_addr,
  input  logic [31:0]      i_meas_data,
  input  logic [4:0]       meas_rd_addr,
  output logic [31:0]      i_q_measurement,
  output logic             o_late,
  output logic             o_overflow,
  output logic             o_done
);

  q_state_e         state_reg;
  logic [TS_W-1:0]  timer_reg;
  logic [TS_W-1:0]  ts_reg;
  logic [TS_W-1:0]  ts_next;
  logic             valid_reg;
  logic [31:0]      inst_reg;
  logic             kind_reg;
  logic             late_reg;
  logic             overflow_reg;
  logic             done_reg;

  q_entry_t         push_entry;
  q_entry_t         fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             run_phase;
  logic             due;

  logic [31:0]      result_reg [MEAS_N];

  // A timestamp write in the push cycle is forwarded into the pushed entry.
  always_comb begin
    ts_next = ts_reg;
    if (q_time_write) ts_next = q_time_sel ? (ts_reg + q_time_reg) : q_time_reg;
  end

  assign push            = q_slm | q_rot;
  assign push_entry.ts   = ts_next;
  assign push_entry.kind = q_rot ? KIND_ROT : KIND_SLM;
  assign push_entry.inst = q_inst;

  assign run_phase = (state_reg == RUN) || (state_reg == DRAIN);
  assign due       = run_phase && !fifo_empty && ts_reached(timer_reg, fifo_head.ts);
  assign pop       = due && (!valid_reg || iss.i_issue_ready);

  q_ts_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      ts_reg       <= '0;
      valid_reg    <= 1'b0;
      inst_reg     <= '0;
      kind_reg     <= 1'b0;
      late_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      ts_reg <= ts_next;

      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
      if (pop && (timer_reg > fifo_head.ts)) late_reg <= 1'b1;

      // Output register: refill on pop, otherwise retire on handshake.
      if (pop) begin
        valid_reg <= 1'b1;
        inst_reg  <= fifo_head.inst;
        kind_reg  <= fifo_head.kind;
      end else if (valid_reg && iss.i_issue_ready) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (i_start) begin
            state_reg <= RUN;
            timer_reg <= '0;
          end
        end
        RUN: begin
          timer_reg <= timer_reg + 1'b1;
          if (i_end) state_reg <= DRAIN;
        end
        DRAIN: begin
          timer_reg <= timer_reg + 1'b1;
          if (fifo_empty && !valid_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          if (i_start) begin
            state_reg <= RUN;
            timer_reg <= '0;
            done_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Result file: one register per entry so reset can clear the whole file.
  genvar gi;
  generate
    for (gi = 0; gi < MEAS_N; gi++) begin : g_result
      always_ff @(posedge clk) begin
        if (!rst) begin
          result_reg[gi] <= '0;
        end else if (i_meas_valid && (i_meas_addr == 5'(gi))) begin
          result_reg[gi] <= i_meas_data;
        end
      end
    end
  endgenerate

  assign i_q_measurement   = result_reg[meas_rd_addr];

  assign o_cc_full         = fifo_full;
  assign iss.o_issue_valid = valid_reg;
  assign iss.o_issue_inst  = inst_reg;
  assign iss.o_issue_kind  = kind_reg;
  assign o_late            = late_reg;
  assign o_overflow        = overflow_reg;
  assign o_done            = done_reg;

endmodule

// File: tb/tb_q_timed_issue.sv
// Directed bench for q_timed_issue: timestamped release, late/overflow flags,
// backpressure, result file and drain-to-done.
module tb_q_timed_issue;
  import q_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_end = 1'b0;
  logic        q_time_write = 1'b0;
  logic        q_time_sel = 1'b0;
  logic [31:0] q_time_reg = '0;
  logic        q_slm = 1'b0;
  logic        q_rot = 1'b0;
  logic [31:0] q_inst = '0;
  logic        o_cc_full;
  logic        i_meas_valid = 1'b0;
  logic [4:0]  i_meas_addr = '0;
  logic [31:0] i_meas_data = '0;
  logic [4:0]  meas_rd_addr = '0;
  logic [31:0] i_q_measurement;
  logic        o_late;
  logic        o_overflow;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int issued = 0;

  q_timed_issue_if iss();

  q_timed_issue dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_end           (i_end),
    .q_time_write    (q_time_write),
    .q_time_sel      (q_time_sel),
    .q_time_reg      (q_time_reg),
    .q_slm           (q_slm),
    .q_rot           (q_rot),
    .q_inst          (q_inst),
    .o_cc_full       (o_cc_full),
    .iss             (iss),
    .i_meas_valid    (i_meas_valid),
    .i_meas_addr     (i_meas_addr),
    .i_meas_data     (i_meas_data),
    .meas_rd_addr    (meas_rd_addr),
    .i_q_measurement (i_q_measurement),
    .o_late          (o_late),
    .o_overflow      (o_overflow),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iss.i_issue_ready = 1'b0;

    // Reset state
    step(2);
    chk("rst_valid", iss.o_issue_valid, 0);
    chk("rst_full", o_cc_full, 0);
    chk("rst_late", o_late, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_done", o_done, 0);
    chk("rst_meas", i_q_measurement, 0);
    rst = 1'b1;
    step();

    // T1: ts=5 absolute with push in IDLE, start, issue the cycle after timer==5
    q_time_write = 1'b1; q_time_sel = 1'b0; q_time_reg = 32'd5;
    q_slm = 1'b1; q_inst = 32'hA0;
    step();
    q_time_write = 1'b0; q_slm = 1'b0;
    iss.i_issue_ready = 1'b1;
    i_start = 1'b1;
    step();                       // first RUN cycle, timer 0
    i_start = 1'b0;
    step(5);                      // timer 5: due now, not yet presented
    chk("t1_early", iss.o_issue_valid, 0);
    step();                       // timer 6
    chk("t1_valid", iss.o_issue_valid, 1);
    chk("t1_inst", iss.o_issue_inst, 32'hA0);
    chk("t1_kind", iss.o_issue_kind, 0);
    chk("t1_late", o_late, 0);
    step();                       // timer 7
    chk("t1_retire", iss.o_issue_valid, 0);

    // T2: abs 10, rel +3, rot push -> ts 13
    q_time_write = 1'b1; q_time_sel = 1'b0; q_time_reg = 32'd10;
    step();                       // timer 8
    q_time_sel = 1'b1; q_time_reg = 32'd3;
    step();                       // timer 9
    q_time_write = 1'b0; q_rot = 1'b1; q_inst = 32'hB1;
    step();                       // timer 10
    q_rot = 1'b0;
    step(3);                      // timer 13
    chk("t2_early", iss.o_issue_valid, 0);
    step();                       // timer 14
    chk("t2_valid", iss.o_issue_valid, 1);
    chk("t2_inst", iss.o_issue_inst, 32'hB1);
    chk("t2_kind", iss.o_issue_kind, 1);
    chk("t2_late", o_late, 0);
    step();                       // timer 15

    // T3: three ts=2 entries pushed from timer 20 -> back-to-back late issues
    step(5);                      // timer 20
    q_time_write = 1'b1; q_time_sel = 1'b0; q_time_reg = 32'd2;
    q_slm = 1'b1; q_inst = 32'hC0;
    step();                       // timer 21
    q_time_write = 1'b0; q_inst = 32'hC1;
    chk("t3_pre", iss.o_issue_valid, 0);
    step();                       // timer 22
    q_inst = 32'hC2;
    chk("t3_inst0", iss.o_issue_inst, 32'hC0);
    chk("t3_valid0", iss.o_issue_valid, 1);
    step();
    q_slm = 1'b0;
    chk("t3_inst1", iss.o_issue_inst, 32'hC1);
    chk("t3_valid1", iss.o_issue_valid, 1);
    step();
    chk("t3_inst2", iss.o_issue_inst, 32'hC2);
    chk("t3_valid2", iss.o_issue_valid, 1);
    chk("t3_late", o_late, 1);
    step();
    chk("t3_idle", iss.o_issue_valid, 0);

    // T4: reset mid-run, fill 16 in IDLE, 17th overflows, then 16 issues
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t4_rst_late", o_late, 0);
    q_slm = 1'b1;
    for (int i = 0; i < 16; i++) begin
      q_inst = 32'h100 + i;
      if (i == 15) chk("t4_not_full", o_cc_full, 0);
      step();
    end
    chk("t4_full", o_cc_full, 1);
    chk("t4_no_ovf", o_overflow, 0);
    q_inst = 32'h1FF;
    step();
    q_slm = 1'b0;
    chk("t4_ovf", o_overflow, 1);
    chk("t4_full2", o_cc_full, 1);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (iss.o_issue_valid) begin
        chk("t4_inst", iss.o_issue_inst, 32'h100 + issued);
        issued++;
      end
    end
    chk("t4_count", issued, 16);
    chk("t4_drained", o_cc_full, 0);

    // T5: backpressure holds the output and the queue
    iss.i_issue_ready = 1'b0;
    q_slm = 1'b1; q_inst = 32'hD0;
    step();
    q_inst = 32'hD1;
    chk("t5_pre", iss.o_issue_valid, 0);
    step();
    q_slm = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t5_hold_valid", iss.o_issue_valid, 1);
      chk("t5_hold_inst", iss.o_issue_inst, 32'hD0);
      step();
    end
    iss.i_issue_ready = 1'b1;
    step();
    chk("t5_next_inst", iss.o_issue_inst, 32'hD1);
    chk("t5_next_valid", iss.o_issue_valid, 1);
    step();
    chk("t5_empty", iss.o_issue_valid, 0);

    // T6: result file, then drain to done, then reset
    i_meas_valid = 1'b1; i_meas_addr = 5'd7; i_meas_data = 32'hDEADBEEF;
    meas_rd_addr = 5'd7;
    #1;
    chk("t6_no_bypass", i_q_measurement, 0);
    step();
    i_meas_addr = 5'd3; i_meas_data = 32'h12345678;
    chk("t6_rd7", i_q_measurement, 32'hDEADBEEF);
    step();
    i_meas_valid = 1'b0;
    chk("t6_rd7_kept", i_q_measurement, 32'hDEADBEEF);
    meas_rd_addr = 5'd3;
    #1;
    chk("t6_rd3", i_q_measurement, 32'h12345678);

    iss.i_issue_ready = 1'b0;
    q_rot = 1'b1; q_inst = 32'hE0;
    step();
    q_inst = 32'hE1;
    step();
    q_rot = 1'b0;
    i_end = 1'b1;
    step();                       // now DRAIN
    i_end = 1'b0;
    chk("t6_drain_inst0", iss.o_issue_inst, 32'hE0);
    chk("t6_drain_done0", o_done, 0);
    iss.i_issue_ready = 1'b1;
    step();
    chk("t6_drain_inst1", iss.o_issue_inst, 32'hE1);
    chk("t6_drain_valid1", iss.o_issue_valid, 1);
    step();
    chk("t6_pre_done", o_done, 0);
    chk("t6_idle", iss.o_issue_valid, 0);
    step();
    chk("t6_done", o_done, 1);
    step();
    chk("t6_done_hold", o_done, 1);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("t6_restart", o_done, 0);

    meas_rd_addr = 5'd7;
    rst = 1'b0;
    step();
    chk("t6_rst_valid", iss.o_issue_valid, 0);
    chk("t6_rst_late", o_late, 0);
    chk("t6_rst_ovf", o_overflow, 0);
    chk("t6_rst_full", o_cc_full, 0);
    chk("t6_rst_done", o_done, 0);
    chk("t6_rst_meas", i_q_measurement, 0);
    rst = 1'b1;
    step();
    chk("t6_post_done", o_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
